regfile_wb_arbiter: RTL



---
 rtl/riscv_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 62 ++++++
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file widths and architectural constants
//
// Contents:
//   DATA_WIDTH_DEF  default register width
//   ADDR_WIDTH_DEF  default register address width
//   X0_ADDR         index of the hard-wired zero register
//   is_x0()         true when an address names the zero register
package riscv_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int X0_ADDR        = 0;

    function automatic logic is_x0(input logic [ADDR_WIDTH_DEF-1:0] addr);
        return addr == ADDR_WIDTH_DEF'(X0_ADDR);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant generator holding the rotation pointer
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset; forces grant low while high
//   valid      per-requester request vector
//   en         grant enable; 0 blocks all grants
//   xfer       a transfer happened this cycle (advances the pointer)
//   grant      one-hot (or zero) grant, combinational
//   grant_idx  encoded index of the granted requester
module rr_arbiter
    import riscv_pkg::*;
#(
    parameter int N = 3,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] valid,
    input  logic         en,
    input  logic         xfer,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] rr_ptr;
    logic         found;
    int           idx;

    // Scan from rr_ptr upward, wrapping; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !reset && !found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = W'(idx);
            end
        end
    end

    // The winner drops to lowest priority next time round.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            if (grant_idx == W'(N - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port among write-back sources
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   arb_en              global grant enable
//   req_valid           per-requester write request
//   req_addr, req_data  packed per-requester destination and data
//   req_ready           one-hot (or zero) grant, combinational
//   we3, wa3, wd3       registered register-file write port
//   grant_id            requester behind the current wa3/wd3
//   ra1, ra2            reader addresses checked for in-flight writes
//   fwd1, fwd2          reader must take wd3 instead of the register file
//   x0_drop_cnt         saturating count of accepted writes to x0
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_REQ    = 3,
    localparam int GNT_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          we3,
    output logic [ADDR_WIDTH-1:0]         wa3,
    output logic [DATA_WIDTH-1:0]         wd3,
    output logic [GNT_W-1:0]              grant_id,
    input  logic [ADDR_WIDTH-1:0]         ra1,
    input  logic [ADDR_WIDTH-1:0]         ra2,
    output logic                          fwd1,
    output logic                          fwd2,
    output logic [7:0]                    x0_drop_cnt
);

    localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(X0_ADDR);

    logic [GNT_W-1:0]      gnt_idx;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_is_x0;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .valid     (req_valid),
        .en        (arb_en),
        .xfer      (transfer),
        .grant     (req_ready),
        .grant_idx (gnt_idx)
    );

    // Grant already implies valid, but keep the handshake explicit.
    assign transfer = |(req_valid & req_ready);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == GNT_W'(i)) begin
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_is_x0 = (sel_addr == X0);

    // we3 is recomputed every edge so each accepted write yields exactly one pulse;
    // address/data/id hold so wa3/wd3 keep naming the last accepted write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3      <= 1'b0;
            wa3      <= '0;
            wd3      <= '0;
            grant_id <= '0;
        end else begin
            we3 <= transfer && !sel_is_x0;
            if (transfer) begin
                wa3      <= sel_addr;
                wd3      <= sel_data;
                grant_id <= gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_drop_cnt <= '0;
        end else if (transfer && sel_is_x0 && (x0_drop_cnt != 8'hFF)) begin
            x0_drop_cnt <= x0_drop_cnt + 8'd1;
        end
    end

    // A read of x0 must never be forwarded; x0 always reads zero.
    assign fwd1 = we3 && (wa3 == ra1) && (ra1 != X0);
    assign fwd2 = we3 && (wa3 == ra2) && (ra2 != X0);

endmodule
